// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: FSM states, flag bit
// positions, opcode names and default datapath width.
package alu_pkg;

  localparam int W_DEF = 8;
  localparam int CNT_W = 4;

  localparam int FLAG_C = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_NOT  = 3'd5;
  localparam logic [2:0] OP_ANDN = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_EXEC,
    S_HOLD
  } state_t;

endpackage

// File: rtl/contador_ejec.sv
// EXEC settle down-counter: loads on the B-operand handshake, counts down
// while the ALU settles and saturates at zero.
module contador_ejec
  import alu_pkg::*;
#(
  parameter int CW = CNT_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          dec,
  input  logic [CW-1:0] load_val,
  output logic          zero
);

  logic [CW-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/secuenciador_alu.sv
// Command sequencer for an external ALU: takes a command, collects one or two
// operands, waits EXEC_CYCLES for the datapath to settle, then holds the result.
module secuenciador_alu
  import alu_pkg::*;
#(
  parameter int W           = W_DEF,
  parameter int EXEC_CYCLES = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic         cmd_chain,
  input  logic         data_valid,
  output logic         data_ready,
  input  logic [W-1:0] data_in,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_control,
  input  logic [W-1:0] alu_result,
  input  logic         alu_carry,
  input  logic         alu_overflow,
  input  logic         alu_negative,
  input  logic         alu_zero,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_data,
  output logic [3:0]   res_flags,
  output logic         busy
);

  localparam logic [CNT_W-1:0] EXEC_LOAD = CNT_W'(EXEC_CYCLES - 1);

  state_t       state;
  logic [W-1:0] a_reg;
  logic [W-1:0] b_reg;
  logic [W-1:0] last_reg;
  logic [2:0]   op_reg;
  logic         cnt_load;
  logic         cnt_zero;

  // Operands and opcode go to the datapath straight from their registers.
  assign alu_a       = a_reg;
  assign alu_b       = b_reg;
  assign alu_control = op_reg;

  assign cnt_load = (state == S_LOAD_B) && data_valid;

  contador_ejec #(.CW(CNT_W)) u_contador (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .dec      (state == S_EXEC),
    .load_val (EXEC_LOAD),
    .zero     (cnt_zero)
  );

  // Handshake and status outputs are registered alongside each transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      last_reg   <= '0;
      op_reg     <= '0;
      res_data   <= '0;
      res_flags  <= '0;
      res_valid  <= 1'b0;
      cmd_ready  <= 1'b1;
      data_ready <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_reg     <= cmd_op;
            cmd_ready  <= 1'b0;
            data_ready <= 1'b1;
            busy       <= 1'b1;
            if (cmd_chain) begin
              a_reg <= last_reg;
              state <= S_LOAD_B;
            end else begin
              state <= S_LOAD_A;
            end
          end
        end
        S_LOAD_A: begin
          if (data_valid) begin
            a_reg <= data_in;
            state <= S_LOAD_B;
          end
        end
        S_LOAD_B: begin
          if (data_valid) begin
            b_reg      <= data_in;
            data_ready <= 1'b0;
            state      <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (cnt_zero) begin
            res_data          <= alu_result;
            last_reg          <= alu_result;
            res_flags[FLAG_C] <= alu_carry;
            res_flags[FLAG_V] <= alu_overflow;
            res_flags[FLAG_N] <= alu_negative;
            res_flags[FLAG_Z] <= alu_zero;
            res_valid         <= 1'b1;
            state             <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state      <= S_IDLE;
          res_valid  <= 1'b0;
          cmd_ready  <= 1'b1;
          data_ready <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_secuenciador_alu.sv
// Bench for secuenciador_alu: two instances (EXEC_CYCLES 1 and 4) share one
// stimulus port through a select, with a behavioural ALU stub and result model.
module tb_secuenciador_alu;

  logic       clk = 1'b0;
  logic       rst;
  logic       sel;
  logic       cmd_valid, cmd_chain, data_valid, res_ready;
  logic [2:0] cmd_op;
  logic [7:0] data_in;
  logic [7:0] noise;
  logic [7:0] alu_result, stub_res;
  logic [3:0] stub_flg;

  logic       cr0, dr0, rv0, bz0, cr1, dr1, rv1, bz1;
  logic [7:0] a0, b0, rd0, a1, b1, rd1;
  logic [2:0] ac0, ac1;
  logic [3:0] rf0, rf1;

  logic       m_cmd_ready, m_data_ready, m_res_valid, m_busy;
  logic [7:0] m_alu_a, m_alu_b, m_res_data;
  logic [2:0] m_alu_control;
  logic [3:0] m_res_flags;

  int         n_checks = 0;
  int         n_err    = 0;
  logic [7:0] last_res [2];

  always #5 clk = ~clk;

  secuenciador_alu #(.W(8), .EXEC_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid & ~sel), .cmd_ready(cr0), .cmd_op(cmd_op), .cmd_chain(cmd_chain),
    .data_valid(data_valid & ~sel), .data_ready(dr0), .data_in(data_in),
    .alu_a(a0), .alu_b(b0), .alu_control(ac0), .alu_result(alu_result),
    .alu_carry(stub_flg[3]), .alu_overflow(stub_flg[2]),
    .alu_negative(stub_flg[1]), .alu_zero(stub_flg[0]),
    .res_valid(rv0), .res_ready(res_ready & ~sel), .res_data(rd0), .res_flags(rf0),
    .busy(bz0)
  );

  secuenciador_alu #(.W(8), .EXEC_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid & sel), .cmd_ready(cr1), .cmd_op(cmd_op), .cmd_chain(cmd_chain),
    .data_valid(data_valid & sel), .data_ready(dr1), .data_in(data_in),
    .alu_a(a1), .alu_b(b1), .alu_control(ac1), .alu_result(alu_result),
    .alu_carry(stub_flg[3]), .alu_overflow(stub_flg[2]),
    .alu_negative(stub_flg[1]), .alu_zero(stub_flg[0]),
    .res_valid(rv1), .res_ready(res_ready & sel), .res_data(rd1), .res_flags(rf1),
    .busy(bz1)
  );

  assign m_cmd_ready   = sel ? cr1 : cr0;
  assign m_data_ready  = sel ? dr1 : dr0;
  assign m_res_valid   = sel ? rv1 : rv0;
  assign m_busy        = sel ? bz1 : bz0;
  assign m_alu_a       = sel ? a1  : a0;
  assign m_alu_b       = sel ? b1  : b0;
  assign m_alu_control = sel ? ac1 : ac0;
  assign m_res_data    = sel ? rd1 : rd0;
  assign m_res_flags   = sel ? rf1 : rf0;

  // Reference ALU: returns {C,V,N,Z,result}.
  function automatic logic [11:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] op);
    logic [8:0] s;
    logic [7:0] r;
    logic       c, v;
    c = 1'b0;
    v = 1'b0;
    case (op)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[7:0];
        c = s[8];
        v = (a[7] == b[7]) && (r[7] != a[7]);
      end
      3'd1: begin
        r = a - b;
        c = (a < b);
        v = (a[7] != b[7]) && (r[7] != a[7]);
      end
      3'd2:    r = a & b;
      3'd3:    r = a | b;
      3'd4:    r = a ^ b;
      3'd5:    r = ~a;
      3'd6:    r = a & ~b;
      default: r = b;
    endcase
    return {c, v, r[7], (r == 8'h00), r};
  endfunction

  // The stub ALU follows the selected DUT's operand outputs; noise lets the
  // bench disturb the result while the sequencer is still settling.
  always_comb begin
    {stub_flg, stub_res} = alu_ref(m_alu_a, m_alu_b, m_alu_control);
    alu_result = stub_res ^ noise;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full command; table mode supplies the expected result, random mode
  // derives it from the model with the noise present at the capture edge.
  task automatic do_cmd(input logic s, input logic [2:0] op, input logic chain,
                        input logic [7:0] d0, input logic [7:0] d1, input int stall,
                        input bit use_exp, input logic [7:0] t_res, input logic [3:0] t_flg);
    logic [7:0]  exp_a, e_res, cap;
    logic [3:0]  e_flg;
    logic [11:0] rr;
    int          n_exec;
    n_exec = s ? 4 : 1;
    sel = s;
    cap = 8'h00;
    check("idle_cmd_ready", 32'(m_cmd_ready), 32'd1);
    check("idle_busy", 32'(m_busy), 32'd0);
    cmd_valid = 1'b1; cmd_op = op; cmd_chain = chain;
    data_valid = 1'b1; data_in = d0;
    step();
    cmd_valid = 1'b0; data_valid = 1'b0;
    check("accept_cmd_ready", 32'(m_cmd_ready), 32'd0);
    check("accept_data_ready", 32'(m_data_ready), 32'd1);
    check("accept_busy", 32'(m_busy), 32'd1);
    exp_a = chain ? last_res[s] : d0;
    if (!chain) begin
      repeat ($urandom_range(2)) step();
      data_valid = 1'b1; data_in = d0;
      step();
      data_valid = 1'b0;
      check("load_a_then_b_ready", 32'(m_data_ready), 32'd1);
    end
    repeat ($urandom_range(1)) step();
    data_valid = 1'b1; data_in = d1;
    step();
    data_valid = 1'b0; data_in = 8'($urandom);
    check("alu_a", 32'(m_alu_a), 32'(exp_a));
    check("alu_b", 32'(m_alu_b), 32'(d1));
    check("alu_control", 32'(m_alu_control), 32'(op));
    check("exec_data_ready", 32'(m_data_ready), 32'd0);
    for (int k = 0; k < n_exec; k++) begin
      noise = use_exp ? 8'h00 : 8'($urandom);
      cap = noise;
      if (k > 0) check("res_valid_early", 32'(m_res_valid), 32'd0);
      step();
    end
    rr = alu_ref(exp_a, d1, op);
    e_res = use_exp ? t_res : (rr[7:0] ^ cap);
    e_flg = use_exp ? t_flg : rr[11:8];
    check("res_valid_latency", 32'(m_res_valid), 32'd1);
    check("res_data", 32'(m_res_data), 32'(e_res));
    check("res_flags", 32'(m_res_flags), 32'(e_flg));
    for (int k = 0; k < stall; k++) begin
      cmd_valid = 1'($urandom); data_valid = 1'($urandom); noise = 8'($urandom);
      step();
      check("hold_res_valid", 32'(m_res_valid), 32'd1);
      check("hold_res_data", 32'(m_res_data), 32'(e_res));
      check("hold_res_flags", 32'(m_res_flags), 32'(e_flg));
      check("hold_cmd_ready", 32'(m_cmd_ready), 32'd0);
      check("hold_data_ready", 32'(m_data_ready), 32'd0);
      check("hold_alu_a", 32'(m_alu_a), 32'(exp_a));
    end
    cmd_valid = 1'b0; data_valid = 1'b0; noise = 8'h00;
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check("release_res_valid", 32'(m_res_valid), 32'd0);
    check("release_cmd_ready", 32'(m_cmd_ready), 32'd1);
    check("release_busy", 32'(m_busy), 32'd0);
    last_res[s] = e_res;
    for (int i = 0; i < 20 && !m_cmd_ready; i++) begin
      res_ready = 1'b1;
      step();
    end
    res_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_alu_a"}, 32'(m_alu_a), 32'd0);
    check({tag, "_alu_b"}, 32'(m_alu_b), 32'd0);
    check({tag, "_alu_control"}, 32'(m_alu_control), 32'd0);
    check({tag, "_res_data"}, 32'(m_res_data), 32'd0);
    check({tag, "_res_flags"}, 32'(m_res_flags), 32'd0);
    check({tag, "_res_valid"}, 32'(m_res_valid), 32'd0);
    check({tag, "_data_ready"}, 32'(m_data_ready), 32'd0);
    check({tag, "_busy"}, 32'(m_busy), 32'd0);
  endtask

  // Drive a command into LOAD_B (or on into HOLD), then reset mid-cycle.
  task automatic reset_mid(input logic s, input bit in_hold);
    sel = s;
    cmd_valid = 1'b1; cmd_op = 3'd0; cmd_chain = 1'b0;
    step();
    cmd_valid = 1'b0; data_valid = 1'b1; data_in = 8'h11;
    step();
    if (in_hold) begin
      data_in = 8'h22;
      step();
      data_valid = 1'b0;
      repeat (s ? 4 : 1) step();
      check("pre_reset_hold", 32'(m_res_valid), 32'd1);
    end else begin
      data_valid = 1'b0;
      check("pre_reset_load_b", 32'(m_data_ready), 32'd1);
    end
    #2 rst = 1'b1;
    #1 check_reset_outputs(in_hold ? "rst_hold" : "rst_load_b");
    #2 rst = 1'b0;
    step();
    check("post_reset_cmd_ready", 32'(m_cmd_ready), 32'd1);
    check("post_reset_busy", 32'(m_busy), 32'd0);
    last_res[0] = 8'h00;
    last_res[1] = 8'h00;
  endtask

  typedef struct {
    logic       sel;
    logic [2:0] op;
    logic       chain;
    logic [7:0] d0;
    logic [7:0] d1;
    int         stall;
    int         pre_rst;   // 0 none, 1 reset in LOAD_B, 2 reset in HOLD
    logic [7:0] exp_res;
    logic [3:0] exp_flg;
  } vec_t;

  vec_t tbl [15];

  initial begin
    tbl[0]  = '{1'b0, 3'd0, 1'b0, 8'h05, 8'h03, 10, 0, 8'h08, 4'b0000};
    tbl[1]  = '{1'b0, 3'd1, 1'b1, 8'h00, 8'h08,  0, 0, 8'h00, 4'b0001};
    tbl[2]  = '{1'b0, 3'd0, 1'b0, 8'h7F, 8'h01,  1, 0, 8'h80, 4'b0110};
    tbl[3]  = '{1'b0, 3'd0, 1'b0, 8'hFF, 8'h01,  0, 0, 8'h00, 4'b1001};
    tbl[4]  = '{1'b0, 3'd1, 1'b0, 8'h03, 8'h05,  0, 0, 8'hFE, 4'b1010};
    tbl[5]  = '{1'b0, 3'd2, 1'b1, 8'h00, 8'h0F,  0, 0, 8'h0E, 4'b0000};
    tbl[6]  = '{1'b0, 3'd4, 1'b0, 8'hAA, 8'hFF,  0, 0, 8'h55, 4'b0000};
    tbl[7]  = '{1'b0, 3'd7, 1'b0, 8'h12, 8'h80,  0, 0, 8'h80, 4'b0010};
    tbl[8]  = '{1'b0, 3'd5, 1'b1, 8'h00, 8'h00,  0, 0, 8'h7F, 4'b0000};
    tbl[9]  = '{1'b0, 3'd3, 1'b0, 8'h00, 8'h00,  0, 0, 8'h00, 4'b0001};
    tbl[10] = '{1'b0, 3'd6, 1'b1, 8'h00, 8'h33,  0, 0, 8'h00, 4'b0001};
    tbl[11] = '{1'b0, 3'd0, 1'b1, 8'h00, 8'h44,  0, 1, 8'h44, 4'b0000};
    tbl[12] = '{1'b1, 3'd0, 1'b0, 8'h20, 8'h22,  3, 0, 8'h42, 4'b0000};
    tbl[13] = '{1'b1, 3'd1, 1'b1, 8'h00, 8'h02,  0, 0, 8'h40, 4'b0000};
    tbl[14] = '{1'b1, 3'd0, 1'b1, 8'h00, 8'h10,  0, 2, 8'h10, 4'b0000};

    rst = 1'b1; sel = 1'b0;
    cmd_valid = 1'b0; cmd_op = 3'd0; cmd_chain = 1'b0;
    data_valid = 1'b0; data_in = 8'h00; res_ready = 1'b0; noise = 8'h00;
    last_res[0] = 8'h00;
    last_res[1] = 8'h00;
    repeat (2) step();
    check_reset_outputs("in_reset");
    rst = 1'b0;
    step();
    check("reset_release_cmd_ready", 32'(m_cmd_ready), 32'd1);

    for (int i = 0; i < 15; i++) begin
      if (tbl[i].pre_rst != 0) reset_mid(tbl[i].sel, tbl[i].pre_rst == 2);
      do_cmd(tbl[i].sel, tbl[i].op, tbl[i].chain, tbl[i].d0, tbl[i].d1,
             tbl[i].stall, 1'b1, tbl[i].exp_res, tbl[i].exp_flg);
    end

    for (int i = 0; i < 40; i++) begin
      do_cmd(1'($urandom), 3'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
             int'($urandom_range(3)), 1'b0, 8'h00, 4'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
